// File: rtl/elastic_pipe.sv
// elastic_pipe: STAGES-deep chain of 2-entry skid buffers (registered ready) with synchronous flush.
// Defining PIPE_STALL_CNT_EN adds stall_cnt, a saturating count of out_valid & !out_ready cycles.
module elastic_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
   ,
   output logic [31:0]      stall_cnt
`endif
);
   logic [STAGES-1:0] mv_q, mv_d, sv_q, sv_d;
   logic [STAGES-1:0][WIDTH-1:0] md_q, md_d, sd_q, sd_d;
   logic [STAGES:0] v, r;
   logic [STAGES:0][WIDTH-1:0] d;
   // Boundary i feeds stage i; boundary STAGES is the output port.
   assign v = {mv_q, in_valid};
   assign d = {md_q, in_data};
   assign r = {out_ready, ~sv_q};
   assign in_ready  = r[0];
   assign out_valid = v[STAGES];
   assign out_data  = d[STAGES];
   always_comb begin
      mv_d = mv_q;
      md_d = md_q;
      sv_d = sv_q;
      sd_d = sd_q;
      for (int i = 0; i < STAGES; i++) begin
         if (!mv_q[i] || r[i+1]) begin
            mv_d[i] = sv_q[i] | (v[i] & r[i]);
            md_d[i] = sv_q[i] ? sd_q[i] : (v[i] & r[i]) ? d[i] : '0;
         end
         sv_d[i] = sv_q[i] ? !r[i+1] : mv_q[i] & !r[i+1] & v[i];
         sd_d[i] = sv_d[i] ? (sv_q[i] ? sd_q[i] : d[i]) : '0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         mv_q <= '0;
         sv_q <= '0;
         md_q <= '0;
         sd_q <= '0;
      end else begin
         mv_q <= mv_d;
         sv_q <= sv_d;
         md_q <= md_d;
         sd_q <= sd_d;
      end
   end
`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   assign stall_cnt_d = (out_valid && !out_ready && !(&stall_cnt_q)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
   always_ff @(posedge clk) stall_cnt_q <= rst ? '0 : stall_cnt_d;
   assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_elastic_pipe.sv
// tb_elastic_pipe: directed and scoreboard checks of elastic_pipe (WIDTH=32, STAGES=2).
// stall_cnt checks are compiled in when PIPE_STALL_CNT_EN is defined.
module tb_elastic_pipe;
   logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_data, out_data;
`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif
   int checks = 0;
   int errors = 0;

   elastic_pipe #(.WIDTH(32), .STAGES(2)) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data)
`ifdef PIPE_STALL_CNT_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] q[$];
      logic [31:0] prev_data;
      logic        prev_stall;
      int idx, sent, rcvd, cyc;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_v", out_valid, 0);
      chk("rst_d", out_data, 0);
      chk("rst_rdy", in_ready, 1);
      // Streaming: 1..8 from cycle 0, first word out in cycle 2.
      out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         in_valid = k < 8;
         in_data = k + 1;
         chk("stream_rdy", in_ready, 1);
         chk("stream_v", out_valid, (k >= 2 && k < 10));
         chk("stream_d", out_data, (k >= 2 && k < 10) ? k - 1 : 0);
         tick();
      end
      // Fill with out_ready=0: only four words fit.
      out_ready = 1'b0;
      idx = 0;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         in_data = 32'hA0 + idx;
         chk("fill_rdy", in_ready, k < 4);
         chk("fill_v", out_valid, k >= 2);
         chk("fill_d", out_data, k >= 2 ? 32'hA0 : 0);
         if (in_ready) idx++;
         tick();
      end
      chk("fill_cnt", idx, 4);
      chk("fill_full", in_ready, 0);
      out_ready = 1'b1;
      for (int j = 0; j < 10; j++) begin
         in_valid = idx < 8;
         in_data = 32'hA0 + idx;
         chk("drain_rdy", in_ready, j >= 2);
         chk("drain_v", out_valid, j < 8);
         chk("drain_d", out_data, j < 8 ? 32'hA0 + j : 0);
         if (in_valid && in_ready) idx++;
         tick();
      end
      chk("drain_cnt", idx, 8);
      // Random backpressure against a FIFO scoreboard.
      sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
      while (rcvd < 1000 && cyc < 20000) begin
         in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
         in_data = $urandom;
         out_ready = $urandom_range(0, 1) == 1;
         if (prev_stall) begin
            chk("hold_v", out_valid, 1);
            chk("hold_d", out_data, prev_data);
         end
         if (in_valid && in_ready) begin
            q.push_back(in_data);
            sent++;
         end
         if (out_valid && out_ready) begin
            chk("rand_d", out_data, q.size() > 0 ? q.pop_front() : 32'hDEAD_BEEF);
            rcvd++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data = out_data;
         tick();
         cyc++;
      end
      chk("rand_cnt", rcvd, 1000);
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      tick();
      chk("rand_empty", out_valid, 0);
      // Flush with three words in flight while 0x55 is offered.
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data = 32'hB1 + k;
         chk("fl_acc", in_ready, 1);
         tick();
      end
      in_data = 32'h55;
      flush = 1'b1;
      chk("fl_rdy", in_ready, 1);
      chk("fl_pre_v", out_valid, 1);
      chk("fl_pre_d", out_data, 32'hB1);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("fl_v", out_valid, 0);
      chk("fl_d", out_data, 0);
      chk("fl_r", in_ready, 1);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("fl_empty", out_valid, 0);
      end
      // Reset while full, then 0x77 emerges after two cycles.
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data = 32'hC0 + k;
         tick();
      end
      chk("rf_full", in_ready, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rf_v", out_valid, 0);
      chk("rf_d", out_data, 0);
      chk("rf_r", in_ready, 1);
      in_data = 32'h77;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("rf_lat1", out_valid, 0);
      tick();
      chk("rf_v2", out_valid, 1);
      chk("rf_d2", out_data, 32'h77);
      tick();
      chk("rf_end", out_valid, 0);
`ifdef PIPE_STALL_CNT_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("sc_rst", stall_cnt, 0);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 32'h99;
      tick();
      in_valid = 1'b0;
      tick();
      chk("sc_v", out_valid, 1);
      chk("sc_zero", stall_cnt, 0);
      for (int k = 0; k < 10; k++) tick();
      chk("sc_ten", stall_cnt, 10);
      out_ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("sc_flush", stall_cnt, 10);
      chk("sc_fv", out_valid, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("sc_clr", stall_cnt, 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
